mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port OTTER block-RAM memory between the instruction-fetch port and the load/store data port of the multicycle CPU.
- Accepts one request per requester, picks an owner by two-way round-robin, and drives the memory-side bus for exactly one cycle.
- Captures the one-cycle-latency read data and returns it to the owner with a done pulse.
- Sits between the CPU control unit and the memory module; all memory traffic passes through it.

Parameters:
- ADDR_WIDTH, 32, width of the requester and memory address buses.
- BUS_WIDTH, 32, data width of wdata/rdata.
- FETCH_FIRST, 1, which port wins a simultaneous request after reset (1 = fetch, 0 = data).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high with payload stable until if_done.
- if_addr  in  ADDR_WIDTH  fetch address; size is implicitly WORD, read only.
- if_done  out  1  one-cycle pulse: fetch access complete.
- if_rdata  out  BUS_WIDTH  fetch read data, valid when if_done = 1.
- if_err  out  1  fetch access error, valid when if_done = 1.
- d_req  in  1  data request; held high with payload stable until d_done.
- d_wr  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_size  in  2  00 BYTE, 01 HALF, 10 WORD, 11 invalid.
- d_wdata  in  BUS_WIDTH  store data.
- d_done  out  1  one-cycle pulse: data access complete.
- d_rdata  out  BUS_WIDTH  load data (raw word), valid when d_done = 1.
- d_err  out  1  data access error, valid when d_done = 1.
- m_addr  out  ADDR_WIDTH  memory address.
- m_size  out  2  memory access size.
- m_rd  out  1  memory read strobe.
- m_wr  out  1  memory write strobe.
- m_wdata  out  BUS_WIDTH  memory write data.
- m_rdata  in  BUS_WIDTH  memory read data; valid one cycle after m_rd.
- m_error  in  1  combinational address/alignment error from memory for the current m_addr/m_size.

Behaviour:
- States: IDLE, ACCESS, RESP. Reset puts the FSM in IDLE.
- Reset values: all done, err and rdata outputs 0; m_rd = m_wr = 0; m_addr, m_size, m_wdata = 0; round-robin pointer = FETCH_FIRST.
- IDLE:
  - No request: stay in IDLE.
  - One request: latch that port's payload into the owner registers and go to ACCESS.
  - Both requests: the round-robin pointer picks the owner, then the pointer flips to the other port.
- ACCESS (exactly 1 cycle):
  - m_addr, m_size, m_wdata are driven from the latched registers.
  - Fetch owner: m_size = WORD.
  - Strobes: m_rd = !wr and m_wr = wr, both gated by !m_error, !size_invalid and !rst.
  - Latch acc_err = m_error | size_invalid, where size_invalid = (size == 11).
  - Always go to RESP.
- RESP (exactly 1 cycle):
  - Owner's done = 1; owner's rdata = m_rdata (0 on a write or on error); owner's err = acc_err.
  - m_rd = m_wr = 0.
  - Arbitrate considering only the non-owner port; the owner's req in this cycle is ignored.
  - If the non-owner port is requesting: latch it and go to ACCESS. Otherwise go to IDLE.
- Latency: req seen in IDLE at cycle N → memory strobe at N+1 → done at N+2.
- Throughput: both ports continuously requesting alternate, with one access every 2 cycles.
- On an error, no memory write or read strobe is ever issued; done and err still pulse, so there is no hang.
- rst asserted in any state: strobes are forced low in that same cycle, so no write commits at that edge. The FSM goes to IDLE, any pending done is dropped, and the pointer is reset.
- A requester dropping req before done is a protocol violation. The arbiter still completes the latched access.

Decomposition:
- Package otter_mem_pkg holds:
  - size_t enum (BYTE/HALF/WORD).
  - owner_t enum (OWN_IF/OWN_D).
  - arb_state_t enum (IDLE/ACCESS/RESP).
- Sub-module rr_arb2: two-way round-robin picker.
  - Inputs: req[1:0], ptr, mask.
  - Outputs: grant[1:0], next_ptr.
  - Combinational, with the pointer register kept in mem_arbiter.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x100, memory word = 0xDEADBEEF → m_rd = 1 at N+1 with m_addr = 0x100 and m_size = 10; if_done = 1 at N+2 with if_rdata = 0xDEADBEEF and if_err = 0.
- Byte store then load: d_wr = 1, d_size = 00, d_addr = 0x203, d_wdata = 0x000000AA → m_wr pulse lasts one cycle. A following word load of 0x200 returns byte 3 = 0xAA with the other bytes unchanged.
- Contention after reset with FETCH_FIRST = 1: both requesters held high → grants go IF, D, IF, D; each done arrives 2 cycles after the previous one.
- Misaligned word store: d_addr = 0x202, d_size = 10, memory error = 1 → m_wr stays 0; d_done = 1 and d_err = 1 at N+2; a later read of 0x200 shows the old contents.
- Invalid size: d_size = 11 → no strobe; d_done = 1 and d_err = 1.
- Reset mid-access: rst = 1 during an ACCESS store → m_wr = 0 in that cycle, no done pulse, FSM returns to IDLE, and the memory is unchanged.

Source files
------------

// File: rtl/otter_mem_pkg.sv
// rtl/otter_mem_pkg.sv - shared types for the OTTER memory arbiter
package otter_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arb_state_t;

    localparam logic [1:0] SIZE_INVALID = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker; ptr = 1 favours req[1]
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic [1:0] mask,
    output logic [1:0] grant,
    output logic       next_ptr
);

    logic [1:0] eligible;

    assign eligible = req & ~mask;

    always_comb begin
        grant    = eligible;
        next_ptr = ptr;
        if (eligible == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
        // after any grant the other requester gets priority next time
        if (grant[1]) begin
            next_ptr = 1'b0;
        end else if (grant[0]) begin
            next_ptr = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of the single-port OTTER memory
module mem_arbiter
    import otter_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int BUS_WIDTH   = 32,
    parameter int FETCH_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [BUS_WIDTH-1:0]  if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [1:0]            d_size,
    input  logic [BUS_WIDTH-1:0]  d_wdata,
    output logic                  d_done,
    output logic [BUS_WIDTH-1:0]  d_rdata,
    output logic                  d_err,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [1:0]            m_size,
    output logic                  m_rd,
    output logic                  m_wr,
    output logic [BUS_WIDTH-1:0]  m_wdata,
    input  logic [BUS_WIDTH-1:0]  m_rdata,
    input  logic                  m_error
);

    arb_state_t state, state_next;
    owner_t     owner;

    logic                  ptr, ptr_next;
    logic [1:0]            req_vec, mask, grant;
    logic                  load;
    logic                  lat_wr;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [1:0]            lat_size;
    logic [BUS_WIDTH-1:0]  lat_wdata;
    logic                  acc_err;
    logic                  size_invalid;
    logic [BUS_WIDTH-1:0]  resp_data;

    // bit 1 is fetch so that ptr = 1 means fetch wins a tie
    assign req_vec      = {if_req, d_req};
    assign size_invalid = (lat_size == SIZE_INVALID);
    assign resp_data    = (!lat_wr && !acc_err) ? m_rdata : '0;

    rr_arb2 u_rr_arb2 (
        .req      (req_vec),
        .ptr      (ptr),
        .mask     (mask),
        .grant    (grant),
        .next_ptr (ptr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mask       = 2'b00;
        load       = 1'b0;
        m_addr     = '0;
        m_size     = 2'b00;
        m_wdata    = '0;
        m_rd       = 1'b0;
        m_wr       = 1'b0;
        if_done    = 1'b0;
        if_rdata   = '0;
        if_err     = 1'b0;
        d_done     = 1'b0;
        d_rdata    = '0;
        d_err      = 1'b0;
        case (state)
            IDLE: begin
                load = |grant;
                if (load) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                m_addr     = lat_addr;
                m_size     = lat_size;
                m_wdata    = lat_wdata;
                m_rd       = !lat_wr && !m_error && !size_invalid && !rst;
                m_wr       = lat_wr && !m_error && !size_invalid && !rst;
                state_next = RESP;
            end
            RESP: begin
                // the current owner cannot win back-to-back
                mask = (owner == OWN_IF) ? 2'b10 : 2'b01;
                load = |grant;
                state_next = load ? ACCESS : IDLE;
                if (!rst) begin
                    if (owner == OWN_IF) begin
                        if_done  = 1'b1;
                        if_rdata = resp_data;
                        if_err   = acc_err;
                    end else begin
                        d_done  = 1'b1;
                        d_rdata = resp_data;
                        d_err   = acc_err;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= (FETCH_FIRST != 0);
            owner     <= OWN_IF;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_size  <= 2'b00;
            lat_wdata <= '0;
            acc_err   <= 1'b0;
        end else begin
            if (load) begin
                ptr <= ptr_next;
                if (grant[1]) begin
                    owner     <= OWN_IF;
                    lat_wr    <= 1'b0;
                    lat_addr  <= if_addr;
                    lat_size  <= SZ_WORD;
                    lat_wdata <= '0;
                end else begin
                    owner     <= OWN_D;
                    lat_wr    <= d_wr;
                    lat_addr  <= d_addr;
                    lat_size  <= d_size;
                    lat_wdata <= d_wdata;
                end
            end
            if (state == ACCESS) begin
                acc_err <= m_error | size_invalid;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a byte-addressed memory model
module tb_mem_arbiter;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] m_addr;
    logic [1:0]  m_size;
    logic        m_rd;
    logic        m_wr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_error;

    logic [7:0]  mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [31:0] pl_data;

    resp_t if_q[$];
    resp_t d_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .BUS_WIDTH(32), .FETCH_FIRST(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .m_addr(m_addr), .m_size(m_size), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_error(m_error)
    );

    // memory flags misalignment and anything past 1 KiB; size 11 is left to the arbiter
    always_comb begin
        m_error = 1'b0;
        if (m_addr >= 32'd1024) m_error = 1'b1;
        if (m_size == 2'b01 && m_addr[0]) m_error = 1'b1;
        if (m_size == 2'b10 && m_addr[1:0] != 2'b00) m_error = 1'b1;
    end

    always @(posedge clk) begin
        logic [9:0] a;
        logic [9:0] b;
        a = m_addr[9:0];
        b = {m_addr[9:2], 2'b00};
        if (pl_en) begin
            mem[pl_addr]         <= pl_data[7:0];
            mem[pl_addr + 10'd1] <= pl_data[15:8];
            mem[pl_addr + 10'd2] <= pl_data[23:16];
            mem[pl_addr + 10'd3] <= pl_data[31:24];
        end else if (m_wr) begin
            mem[a] <= m_wdata[7:0];
            if (m_size != 2'b00) mem[a + 10'd1] <= m_wdata[15:8];
            if (m_size[1]) begin
                mem[a + 10'd2] <= m_wdata[23:16];
                mem[a + 10'd3] <= m_wdata[31:24];
            end
        end
        if (m_rd) m_rdata <= {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        resp_t e;
        if (!rst && if_done) begin
            if (if_q.size() == 0) begin
                chk("if_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = if_q.pop_front();
                chk("if_rdata", if_rdata, e.rdata);
                chk("if_err", {31'd0, if_err}, {31'd0, e.err});
            end
        end
        if (!rst && d_done) begin
            if (d_q.size() == 0) begin
                chk("d_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = d_q.pop_front();
                chk("d_rdata", d_rdata, e.rdata);
                chk("d_err", {31'd0, d_err}, {31'd0, e.err});
            end
        end
    end

    task automatic preload(input logic [9:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = addr; pl_data = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // single-requester access from IDLE: strobe one cycle later, done two cycles later
    task automatic access(input string name, input logic port_d, input logic wr,
                          input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        resp_t e;
        logic  exp_rd, exp_wr;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_rd  = !exp_err && !wr;
        exp_wr  = !exp_err && wr;
        if (port_d) d_q.push_back(e); else if_q.push_back(e);
        @(posedge clk); #1;
        if (port_d) begin
            d_req = 1'b1; d_wr = wr; d_addr = addr; d_size = size; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk({name, "_idle_strobe"}, {30'd0, m_rd, m_wr}, 32'd0);
            end else if (k == 1) begin
                chk({name, "_m_rd"}, {31'd0, m_rd}, {31'd0, exp_rd});
                chk({name, "_m_wr"}, {31'd0, m_wr}, {31'd0, exp_wr});
                chk({name, "_m_addr"}, m_addr, addr);
                chk({name, "_m_size"}, {30'd0, m_size}, {30'd0, (port_d ? size : 2'b10)});
            end else begin
                chk({name, "_done"}, {31'd0, (port_d ? d_done : if_done)}, 32'd1);
                chk({name, "_resp_strobe"}, {30'd0, m_rd, m_wr}, 32'd0);
            end
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    initial begin
        resp_t e;
        logic  drop_if, drop_d;
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_size = 2'b10; d_wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        preload(10'h100, 32'hDEADBEEF);
        preload(10'h200, 32'h11223344);
        preload(10'h300, 32'h01020304);
        preload(10'h304, 32'hA5A5F00F);
        @(negedge clk);
        chk("rst_done", {30'd0, if_done, d_done}, 32'd0);
        chk("rst_err", {30'd0, if_err, d_err}, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        chk("rst_strobe", {30'd0, m_rd, m_wr}, 32'd0);
        chk("rst_m_bus", m_addr | m_wdata | {30'd0, m_size}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // contention right after reset: IF, D, IF, D on every other cycle
        e.err = 1'b0;
        e.rdata = 32'h01020304; if_q.push_back(e); if_q.push_back(e);
        e.rdata = 32'hA5A5F00F; d_q.push_back(e); d_q.push_back(e);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h304; d_size = 2'b10;
        drop_if = 1'b0; drop_d = 1'b0;
        for (int k = 0; k < 11; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (drop_if) if_req = 1'b0;
                if (drop_d) d_req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("cont_if_done_c%0d", k), {31'd0, if_done}, {31'd0, (k == 2 || k == 6)});
            chk($sformatf("cont_d_done_c%0d", k), {31'd0, d_done}, {31'd0, (k == 4 || k == 8)});
            if (k == 1) chk("cont_first_addr", m_addr, 32'h300);
            if (k == 3) chk("cont_second_addr", m_addr, 32'h304);
            drop_if = (k == 6);
            drop_d  = (k == 8);
        end

        access("fetch", 1'b0, 1'b0, 32'h100, 2'b10, 32'h0, 32'hDEADBEEF, 1'b0);
        access("sb", 1'b1, 1'b1, 32'h203, 2'b00, 32'h000000AA, 32'h0, 1'b0);
        access("lw_after_sb", 1'b1, 1'b0, 32'h200, 2'b10, 32'h0, 32'hAA223344, 1'b0);
        access("sw_misaligned", 1'b1, 1'b1, 32'h202, 2'b10, 32'h55667788, 32'h0, 1'b1);
        access("lw_after_bad_sw", 1'b1, 1'b0, 32'h200, 2'b10, 32'h0, 32'hAA223344, 1'b0);
        access("ld_bad_size", 1'b1, 1'b0, 32'h200, 2'b11, 32'h0, 32'h0, 1'b1);
        access("lh_raw_word", 1'b1, 1'b0, 32'h202, 2'b01, 32'h0, 32'hAA223344, 1'b0);
        access("fetch_oob", 1'b0, 1'b0, 32'h400, 2'b10, 32'h0, 32'h0, 1'b1);

        // reset lands during the ACCESS cycle of a store
        @(posedge clk); #1;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h200; d_size = 2'b10; d_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_m_wr", {31'd0, m_wr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_no_done_c%0d", k), {30'd0, if_done, d_done}, 32'd0);
        end
        access("lw_after_rst", 1'b1, 1'b0, 32'h200, 2'b10, 32'h0, 32'hAA223344, 1'b0);

        repeat (4) @(negedge clk);
        chk("if_q_drained", if_q.size(), 32'd0);
        chk("d_q_drained", d_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
